// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared encodings for the multicycle control unit. Holds the
//                opcode, Funct and ALUControl encodings, the ALUOp selector
//                and the controller state enumeration.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_pkg;

    // Opcodes recognised by the decoder
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
//  Module      : mc_aludec
//  Description : ALU decoder. Maps ALUOp (and Funct for R-type) to the
//                3-bit ALUControl and flags whether Funct is one of the
//                supported R-type operations.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       supported
);

    logic [2:0] funct_ctl;

    // Funct field decode; unsupported codes fall back to add and clear the flag
    always_comb begin
        funct_ctl = ALU_ADD;
        supported = 1'b1;
        case (Funct)
            FUNCT_ADD: funct_ctl = ALU_ADD;
            FUNCT_SUB: funct_ctl = ALU_SUB;
            FUNCT_AND: funct_ctl = ALU_AND;
            FUNCT_OR:  funct_ctl = ALU_OR;
            FUNCT_SLT: funct_ctl = ALU_SLT;
            default: begin
                funct_ctl = ALU_ADD;
                supported = 1'b0;
            end
        endcase
    end

    // Select the ALU operation requested by the controller
    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            ALUOP_ADD:   ALUControl = ALU_ADD;
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_ctl;
            default:     ALUControl = 3'b000;
        endcase
    end

endmodule : mc_aludec
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multicycle MIPS-subset controller. Moore FSM sequencing
//                lw, sw, R-type, beq, addi and j through FETCH/DECODE and
//                per-class execute states; ALUControl also depends on Funct
//                and PCEn on the ALU Zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control
    import mc_pkg::*;
#(
    parameter int TRACE = 0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic       funct_ok;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        alu_op     = ALUOP_NONE;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                alu_op     = ALUOP_ADD;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALUOP_ADD;
                case (Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                alu_op     = ALUOP_ADD;
                state_next = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                state_next = FETCH;
            end
            RTYPEEX: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                // An unsupported Funct completes without touching the register file
                RegDst     = 1'b1;
                RegWrite   = funct_ok;
                state_next = FETCH;
            end
            BEQEX: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                alu_op     = ALUOP_ADD;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            JEX: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // PC enable: unconditional writes plus taken branches, same cycle
    assign PCEn = pc_write | (branch & Zero);

    mc_aludec u_aludec (
        .ALUOp      (alu_op),
        .Funct      (Funct),
        .ALUControl (ALUControl),
        .supported  (funct_ok)
    );

    generate
        if (TRACE != 0) begin : g_trace
            // Simulation trace of every state change
            always @(posedge clk) begin
                if (!reset && (state_next != state)) begin
                    $display("mc_control: %0t %s -> %s", $time, state.name(), state_next.name());
                end
            end
        end
    endgenerate

endmodule : mc_control
`default_nettype wire
